// File: rtl/pipeline_ctrl.sv
// Hazard and flow control for a 5-stage in-order pipeline: stage valid tracking,
// load-use interlock, branch redirect, MEM back-pressure and performance counters.
module pipeline_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             if_id_en,
    output logic             if_id_clr,
    output logic             id_ex_en,
    output logic             id_ex_clr,
    output logic             ex_mem_en,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LOAD_USE = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ex_stage_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             v_id_q, v_id_d;
    ex_stage_t        ex_q, ex_d;
    stage_t           mem_q, mem_d;
    stage_t           wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    logic branch;
    logic load_use;

    assign branch   = ex_q.v & ex_branch_taken;
    assign load_use = v_id_q & ex_q.v & ex_q.ld & ex_q.we & (ex_q.rd != '0) &
                      ((id_uses_rs1 & (id_rs1 == ex_q.rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_q.rd)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RUN;
            v_id_q       <= 1'b0;
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            v_id_q       <= v_id_d;
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            wb_q         <= wb_d;
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        v_id_d       = v_id_q;
        ex_d         = ex_q;
        mem_d        = mem_q;
        wb_d         = wb_q;
        stall_cnt_d  = stall_cnt_q;
        retire_cnt_d = retire_cnt_q;

        if (mem_busy) begin
            // IF..MEM freeze; WB drains to a bubble. A pending redirect survives the wait.
            wb_d.v  = 1'b0;
            state_d = (state_q == S_REDIRECT) ? S_REDIRECT : S_MEM_WAIT;
        end else begin
            wb_d     = mem_q;
            mem_d.v  = ex_q.v;
            mem_d.rd = ex_q.rd;
            mem_d.we = ex_q.we;
            if (branch) begin
                v_id_d  = 1'b0;
                ex_d    = '0;
                state_d = S_REDIRECT;
            end else if (load_use) begin
                ex_d    = '0;
                state_d = S_LOAD_USE;
            end else begin
                v_id_d  = if_valid & (state_q != S_REDIRECT);
                ex_d.v  = v_id_q;
                ex_d.rd = id_rd;
                ex_d.we = id_we;
                ex_d.ld = id_is_load;
                state_d = S_RUN;
            end
        end

        if (!pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (wb_q.v && (retire_cnt_q != '1)) begin
            retire_cnt_d = retire_cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        pc_en     = 1'b0;
        pc_sel    = 1'b0;
        if_id_en  = 1'b0;
        if_id_clr = 1'b0;
        id_ex_en  = 1'b0;
        id_ex_clr = 1'b0;
        ex_mem_en = 1'b0;

        if (!rst_n) begin
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else if (!mem_busy) begin
            if (branch) begin
                pc_en     = 1'b1;
                pc_sel    = 1'b1;
                if_id_en  = 1'b1;
                if_id_clr = 1'b1;
                id_ex_en  = 1'b1;
                id_ex_clr = 1'b1;
                ex_mem_en = 1'b1;
            end else if (load_use) begin
                id_ex_en  = 1'b1;
                id_ex_clr = 1'b1;
                ex_mem_en = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
            end
        end

        wb_en      = rst_n & wb_q.v & wb_q.we & (wb_q.rd != '0);
        wb_rd      = wb_q.rd;
        state      = state_q;
        stall_cnt  = stall_cnt_q;
        retire_cnt = retire_cnt_q;
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic
// checked every cycle against an instruction-level pipeline model.
module tb_pipeline_ctrl;

    localparam int unsigned CW   = 6;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n, if_valid, id_uses_rs1, id_uses_rs2, id_we, id_is_load;
    logic          ex_branch_taken, mem_busy;
    logic [4:0]    id_rs1, id_rs2, id_rd;
    logic          pc_en, pc_sel, if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en, wb_en;
    logic [4:0]    wb_rd;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, retire_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .pc_sel(pc_sel), .if_id_en(if_id_en), .if_id_clr(if_id_clr),
        .id_ex_en(id_ex_en), .id_ex_clr(id_ex_clr), .ex_mem_en(ex_mem_en),
        .wb_en(wb_en), .wb_rd(wb_rd), .state(state),
        .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
    );

    // Model: instruction records for EX, MEM, WB plus ID valid, counters kept uncapped.
    typedef struct packed { logic v; logic [4:0] rd; logic we; logic ld; } instr_t;
    instr_t      pipe [3];
    logic        m_vid;
    logic [1:0]  m_state;
    int unsigned m_stall, m_ret;

    int unsigned n_checks = 0, n_fail = 0;
    logic        cap_pc_en, cap_pc_sel, cap_if_id_clr, cap_id_ex_clr, cap_ex_mem_en, cap_wb_en;
    logic [1:0]  cap_state;
    int unsigned cap_stall, cap_ret;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input int unsigned n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_vid = 1'b0; m_state = 2'd0; m_stall = 0; m_ret = 0;
    endtask

    task automatic idle();
        rst_n = 1'b1; if_valid = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        id_rd = '0; id_we = 1'b0; id_is_load = 1'b0;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic we, input logic ld,
                          input logic u1, input logic [4:0] rs1);
        id_rd = rd; id_we = we; id_is_load = ld; id_uses_rs1 = u1; id_rs1 = rs1;
        id_uses_rs2 = 1'b0; id_rs2 = '0;
    endtask

    // One clock: inputs are already driven; check at negedge, advance model, return at posedge+1.
    task automatic step();
        instr_t ex, mem, wb;
        logic   br, lu, e_pc_en, e_pc_sel, e_ifid_en, e_ifid_clr, e_idex_en, e_idex_clr, e_exmem_en, e_wb_en;
        logic   care_ifid_en, care_idex_en;
        int     mode;
        @(negedge clk);
        ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
        br = ex.v & ex_branch_taken;
        lu = m_vid & ex.v & ex.ld & ex.we & (ex.rd != 5'd0) &
             ((id_uses_rs1 & (id_rs1 == ex.rd)) | (id_uses_rs2 & (id_rs2 == ex.rd)));
        if (!rst_n)        mode = 0;
        else if (mem_busy) mode = 1;
        else if (br)       mode = 2;
        else if (lu)       mode = 3;
        else               mode = 4;

        {e_pc_en, e_pc_sel, e_ifid_en, e_ifid_clr, e_idex_en, e_idex_clr, e_exmem_en} = '0;
        care_ifid_en = 1'b1; care_idex_en = 1'b1;
        case (mode)
            0: begin e_ifid_clr = 1'b1; e_idex_clr = 1'b1; end
            2: begin
                e_pc_en = 1'b1; e_pc_sel = 1'b1; e_ifid_clr = 1'b1; e_idex_clr = 1'b1;
                e_exmem_en = 1'b1; care_ifid_en = 1'b0; care_idex_en = 1'b0;
            end
            3: begin e_idex_clr = 1'b1; e_exmem_en = 1'b1; care_idex_en = 1'b0; end
            4: begin e_pc_en = 1'b1; e_ifid_en = 1'b1; e_idex_en = 1'b1; e_exmem_en = 1'b1; end
            default: ;
        endcase
        e_wb_en = rst_n & wb.v & wb.we & (wb.rd != 5'd0);

        check("pc_en",     32'(pc_en),     32'(e_pc_en));
        check("pc_sel",    32'(pc_sel),    32'(e_pc_sel));
        check("if_id_clr", 32'(if_id_clr), 32'(e_ifid_clr));
        check("id_ex_clr", 32'(id_ex_clr), 32'(e_idex_clr));
        check("ex_mem_en", 32'(ex_mem_en), 32'(e_exmem_en));
        check("wb_en",     32'(wb_en),     32'(e_wb_en));
        if (care_ifid_en) check("if_id_en", 32'(if_id_en), 32'(e_ifid_en));
        if (care_idex_en) check("id_ex_en", 32'(id_ex_en), 32'(e_idex_en));
        if (e_wb_en)      check("wb_rd",    32'(wb_rd),    32'(wb.rd));
        check("state",      32'(state),      32'(m_state));
        check("stall_cnt",  32'(stall_cnt),  sat(m_stall));
        check("retire_cnt", 32'(retire_cnt), sat(m_ret));

        cap_pc_en = pc_en; cap_pc_sel = pc_sel; cap_if_id_clr = if_id_clr;
        cap_id_ex_clr = id_ex_clr; cap_ex_mem_en = ex_mem_en; cap_wb_en = wb_en;
        cap_state = state; cap_stall = 32'(stall_cnt); cap_ret = 32'(retire_cnt);

        if (mode != 0 && wb.v) m_ret++;
        if (mode != 0 && !e_pc_en) m_stall++;
        case (mode)
            0: model_clear();
            1: begin pipe[2].v = 1'b0; m_state = (m_state == 2'd3) ? 2'd3 : 2'd2; end
            2: begin pipe[2] = mem; pipe[1] = ex; pipe[0].v = 1'b0; m_vid = 1'b0; m_state = 2'd3; end
            3: begin pipe[2] = mem; pipe[1] = ex; pipe[0].v = 1'b0; m_state = 2'd1; end
            default: begin
                pipe[2] = mem; pipe[1] = ex;
                pipe[0] = '{v: m_vid, rd: id_rd, we: id_we, ld: id_is_load};
                m_vid   = (m_state == 2'd3) ? 1'b0 : if_valid;
                m_state = 2'd0;
            end
        endcase
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic load_use_seq(input logic [4:0] lrd, output logic pc_en_s2,
                                output logic [1:0] st_s3, output int unsigned stall_s3);
        do_reset();
        if_valid = 1'b1; step();
        set_id(lrd, 1'b1, 1'b1, 1'b0, 5'd0); step();
        if_valid = 1'b0; set_id(5'd6, 1'b1, 1'b0, 1'b1, lrd); step();
        pc_en_s2 = cap_pc_en;
        check("lu_idex_clr", 32'(cap_id_ex_clr), 32'(lrd != 5'd0));
        step();
        st_s3 = cap_state; stall_s3 = cap_stall;
        idle(); step();
    endtask

    initial begin
        logic        p;
        logic [1:0]  s;
        int unsigned sc;

        idle(); rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;

        // Independent ALU ops rd=1..4
        for (int k = 0; k < 9; k++) begin
            if_valid = (k < 4);
            set_id((k >= 1 && k <= 4) ? 5'(k) : 5'd0, (k >= 1 && k <= 4), 1'b0, 1'b0, 5'd0);
            step();
            if (k == 3) check("first_wb_early", 32'(cap_wb_en), 32'd0);
            if (k == 4) check("first_wb", 32'(cap_wb_en), 32'd1);
        end
        check("alu_retire", cap_ret, 32'd4);
        check("alu_stall",  cap_stall, 32'd0);

        load_use_seq(5'd5, p, s, sc);
        check("lu_pc_en", 32'(p), 32'd0);
        check("lu_state", 32'(s), 32'd1);
        check("lu_stall", sc, 32'd1);
        load_use_seq(5'd0, p, s, sc);
        check("x0_pc_en", 32'(p), 32'd1);
        check("x0_state", 32'(s), 32'd0);
        check("x0_stall", sc, 32'd0);

        // Taken branch in EX beats a load-use in ID
        do_reset();
        if_valid = 1'b1; step();
        set_id(5'd5, 1'b1, 1'b1, 1'b0, 5'd0); step();
        if_valid = 1'b0; ex_branch_taken = 1'b1; set_id(5'd6, 1'b1, 1'b0, 1'b1, 5'd5); step();
        check("br_pc_sel", 32'(cap_pc_sel), 32'd1);
        check("br_ifid_clr", 32'(cap_if_id_clr), 32'd1);
        check("br_idex_clr", 32'(cap_id_ex_clr), 32'd1);
        check("br_pc_en", 32'(cap_pc_en), 32'd1);
        ex_branch_taken = 1'b0; if_valid = 1'b1; set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
        check("br_redirect", 32'(cap_state), 32'd3);
        check("br_nostall", cap_stall, 32'd0);
        step();
        if_valid = 1'b0;
        repeat (5) step();
        check("br_retire", cap_ret, 32'd2);

        // Branch held under mem_busy for 3 cycles
        do_reset();
        if_valid = 1'b1; step();
        if_valid = 1'b0; set_id(5'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
        ex_branch_taken = 1'b1; mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("busy_pc_en", 32'(cap_pc_en), 32'd0);
            check("busy_exmem", 32'(cap_ex_mem_en), 32'd0);
            check("busy_wb_en", 32'(cap_wb_en), 32'd0);
            if (k > 0) check("busy_state", 32'(cap_state), 32'd2);
        end
        mem_busy = 1'b0; step();
        check("busy_stall", cap_stall, 32'd3);
        check("busy_redir", 32'(cap_pc_sel), 32'd1);
        ex_branch_taken = 1'b0; step();
        check("busy_state_r", 32'(cap_state), 32'd3);

        // Reset during MEM_WAIT
        do_reset();
        if_valid = 1'b1; repeat (3) step();
        mem_busy = 1'b1; repeat (2) step();
        rst_n = 1'b0; step();
        check("rst_ifid_clr", 32'(cap_if_id_clr), 32'd1);
        rst_n = 1'b1; mem_busy = 1'b0; step();
        check("rst_state", 32'(cap_state), 32'd0);
        check("rst_stall", cap_stall, 32'd0);
        check("rst_retire", cap_ret, 32'd0);

        // Random traffic: first with occasional resets, then long enough to saturate counters
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 400; i++) begin
                rst_n           = !(ph == 0 && $urandom_range(0, 60) == 0);
                if_valid        = ($urandom_range(0, 9) < (ph == 0 ? 5 : 9));
                id_rs1          = 5'($urandom_range(0, 7));
                id_rs2          = 5'($urandom_range(0, 7));
                id_rd           = 5'($urandom_range(0, 7));
                id_uses_rs1     = 1'($urandom);
                id_uses_rs2     = 1'($urandom);
                id_we           = 1'($urandom);
                id_is_load      = 1'($urandom);
                ex_branch_taken = ($urandom_range(0, 5) == 0);
                mem_busy        = ($urandom_range(0, 4) == 0);
                step();
            end
        end
        if (m_ret >= CMAX)   check("retire_sat", 32'(retire_cnt), CMAX);
        if (m_stall >= CMAX) check("stall_sat",  32'(stall_cnt),  CMAX);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of performance counters.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 if_valid  in  1  fetch presents a valid instruction this cycle.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
REQ-007 id_rd  in  5  destination register of the ID instruction.
REQ-008 id_we, id_is_load  in  1 each  ID instruction writes rd / is a load.
REQ-009 ex_branch_taken  in  1  branch in EX resolved taken; qualified internally by v_ex.
REQ-010 mem_busy  in  1  MEM stage cannot complete this cycle.
REQ-011 pc_en, pc_sel  out  1 each  PC update enable; 1 = select branch target.
REQ-012 if_id_en, if_id_clr, id_ex_en, id_ex_clr, ex_mem_en  out  1 each  pipeline register enables/clears.
REQ-013 wb_en  out  1  register write this cycle; wb_rd  out  5  destination.
REQ-014 state  out  2  RUN=0, LOAD_USE=1, MEM_WAIT=2, REDIRECT=3.
REQ-015 stall_cnt, retire_cnt  out  CNT_W each  performance counters.

Function
REQ-016 Block SHALL track per-stage valid bits v_id, v_ex, v_mem, v_wb, plus rd/we/is_load for EX, MEM, WB, shifted with the pipeline register enables.
REQ-017 Hazard priority per cycle SHALL be: mem_busy > taken branch (v_ex & ex_branch_taken) > load-use > normal advance.
REQ-018 Load-use SHALL be: v_id & v_ex & ex_is_load & ex_we & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-019 Normal: pc_en, if_id_en, id_ex_en, ex_mem_en = 1; clears 0; v_id <= if_valid; all other stages shift.
REQ-020 mem_busy: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; IF..MEM metadata hold; v_wb <= 0; state <= MEM_WAIT.
REQ-021 Taken branch: pc_en=1, pc_sel=1, if_id_clr=1, id_ex_clr=1; v_id, v_ex <= 0; EX advances to MEM; state <= REDIRECT.
REQ-022 Branch held in EX under mem_busy SHALL redirect on the first non-busy cycle.
REQ-023 Load-use: pc_en=0, if_id_en=0, id_ex_clr=1 (bubble, v_ex <= 0); EX/MEM/WB advance; state <= LOAD_USE; stall lasts exactly 1 cycle (MEM/WB forwarding covers the rest).
REQ-024 REDIRECT (one cycle): if_valid ignored, v_id <= 0, pc_en=1, pc_sel=0; unless mem_busy, then REDIRECT persists until a non-busy cycle.
REQ-025 Otherwise state <= RUN; MEM_WAIT exits to RUN on the first non-busy cycle.
REQ-026 wb_en SHALL equal v_wb & wb_we & wb_rd!=0; wb_rd is the WB-stage rd; x0 is never written.
REQ-027 stall_cnt SHALL increment each non-reset cycle with pc_en=0; retire_cnt each cycle with v_wb=1; both saturate at all-ones.
REQ-028 All outputs except counters and state SHALL be combinational from current inputs and registered stage state.

Reset
REQ-029 On posedge clk with rst_n=0: all valid bits 0, metadata 0, state RUN, counters 0.
REQ-030 While rst_n=0: pc_en, wb_en, all enables = 0; clears = 1.
REQ-031 Reset mid-stall, mid-redirect or mid-MEM_WAIT SHALL discard pending actions; first post-reset cycle is RUN with empty pipeline.

Verification
REQ-032 Reset, then if_valid=1 with independent ALU ops (we=1, rd=1..4) -> first wb_en on 4th cycle after first fetch, retire_cnt=4 after 4 retires, stall_cnt=0.
REQ-033 Load to x5, next instruction reads rs1=x5 -> one cycle pc_en=0, id_ex_clr=1, state=LOAD_USE, stall_cnt=1; load with rd=x0 -> no stall.
REQ-034 Taken branch in EX, same cycle load-use in ID -> pc_sel=1, both clears=1, no stall; next cycle state=REDIRECT, v_id=0 despite if_valid=1.
REQ-035 mem_busy held 3 cycles with branch in EX -> all enables 0, wb_en=0, state=MEM_WAIT, stall_cnt=3; redirect on cycle 4.
REQ-036 Preload retire_cnt to all-ones (force) then retire -> value remains all-ones; rst_n=0 during MEM_WAIT -> next cycle state=RUN, counters 0.
